// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: size encoding plus the byte-lane,
// alignment and load-extension helpers used by the stage and its RAM path.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    localparam int WORD_W  = 32;
    localparam int LANES   = 4;
    localparam int LANE_W  = 8;

    function automatic logic [LANES-1:0] byte_en(input size_e size, input logic [1:0] addr_lo);
        logic [LANES-1:0] en;
        en = '0;
        case (size)
            SZ_BYTE: en = 4'b0001 << addr_lo;
            SZ_HALF: en = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: en = 4'b1111;
            default: en = 4'b0000;
        endcase
        return en;
    endfunction

    function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Store data is right-justified; replicate it so any enabled lane sees it.
    function automatic logic [WORD_W-1:0] store_replicate(input size_e size, input logic [WORD_W-1:0] data);
        logic [WORD_W-1:0] rep;
        rep = data;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                      input size_e size,
                                                      input logic [1:0] addr_lo,
                                                      input logic unsigned_ld);
        logic [WORD_W-1:0] res;
        logic [7:0]        b;
        logic [15:0]       h;
        b   = word[LANE_W*addr_lo +: LANE_W];
        h   = addr_lo[1] ? word[31:16] : word[15:0];
        res = '0;
        case (size)
            SZ_BYTE: res = unsigned_ld ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = unsigned_ld ? {16'd0, h} : {{16{h[15]}}, h};
            SZ_WORD: res = word;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// M-to-W bus for the MEM stage: M-side request fields in, W-side results out.
interface mem_access_stage_if;
    logic        validM;
    logic        stallM;
    logic        memWriteM;
    logic        memReadM;
    logic [1:0]  sizeM;
    logic        unsignedM;
    logic [31:0] ALUOutM;
    logic [31:0] writeDataM;

    logic [31:0] address;
    logic [31:0] ALUOutW;
    logic        validW;
    logic [31:0] readDataW;
    logic        misalignW;

    modport master (
        output validM, stallM, memWriteM, memReadM, sizeM, unsignedM, ALUOutM, writeDataM,
        input  address, ALUOutW, validW, readDataW, misalignW
    );

    modport slave (
        input  validM, stallM, memWriteM, memReadM, sizeM, unsignedM, ALUOutM, writeDataM,
        output address, ALUOutW, validW, readDataW, misalignW
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM with byte write enables; the read returns
// the word as it was before any write in the same cycle.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int INDEX_W     = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               en,
    input  logic [3:0]         we,
    input  logic [INDEX_W-1:0] idx,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data RAM from the M slot and registers the
// W-side view (address, validity, alignment fault, extended load data).
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int INDEX_W     = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_stage_if.slave bus
);

    logic               req;
    logic               fire;
    logic               mis;
    size_e              size_m;
    logic [INDEX_W-1:0] idx;
    logic [3:0]         we;
    logic [31:0]        wdata;
    logic [31:0]        rdata;

    logic [31:0]        address_q;
    logic [31:0]        alu_w_q;
    logic               valid_q;
    logic               mis_q;
    logic               load_q;
    size_e              size_q;
    logic [1:0]         lo_q;
    logic               uns_q;

    assign size_m = size_e'(bus.sizeM);
    assign req    = bus.validM & (bus.memReadM | bus.memWriteM);
    assign fire   = req & ~bus.stallM & ~reset;
    assign mis    = req & misaligned(size_m, bus.ALUOutM[1:0]);
    assign idx    = bus.ALUOutM[2 +: INDEX_W];
    assign we     = (fire & bus.memWriteM & ~mis) ? byte_en(size_m, bus.ALUOutM[1:0]) : 4'b0000;
    assign wdata  = store_replicate(size_m, bus.writeDataM);

    // RAM is only enabled on a live access, so its output holds through stalls.
    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INDEX_W     (INDEX_W)
    ) u_ram (
        .clk   (clk),
        .en    (fire),
        .we    (we),
        .idx   (idx),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            address_q <= '0;
            alu_w_q   <= '0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            load_q    <= 1'b0;
            size_q    <= SZ_BYTE;
            lo_q      <= 2'b00;
            uns_q     <= 1'b0;
        end else if (!bus.stallM) begin
            address_q <= bus.ALUOutM;
            alu_w_q   <= bus.ALUOutM;
            valid_q   <= bus.validM;
            mis_q     <= mis;
            load_q    <= bus.validM & bus.memReadM & ~mis;
            size_q    <= size_m;
            lo_q      <= bus.ALUOutM[1:0];
            uns_q     <= bus.unsignedM;
        end
    end

    assign bus.address   = address_q;
    assign bus.ALUOutW   = alu_w_q;
    assign bus.validW    = valid_q;
    assign bus.misalignW = mis_q;
    assign bus.readDataW = load_q ? load_extend(rdata, size_q, lo_q, uns_q) : 32'd0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random traffic checked
// against a byte-level memory model.
module tb_mem_access_stage;

    logic clk;
    logic reset;

    mem_access_stage_if bif ();

    mem_access_stage #(.DEPTH_WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    logic [31:0] mdl_mem [1024];
    bit          known   [1024];

    logic [31:0] e_addr;
    logic [31:0] e_aluw;
    logic        e_valid;
    logic [31:0] e_rd;
    bit          e_rd_known;
    logic        e_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input int nb,
                                             input int lo, input bit uns);
        longint unsigned v;
        longint unsigned mask;
        v    = longint'(word) >> (8 * lo);
        mask = (64'd1 << (8 * nb)) - 1;
        v    = v & mask;
        if (!uns && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1)
            v = v | (~mask & 64'hFFFF_FFFF);
        return v[31:0];
    endfunction

    task automatic model(input bit r, input bit st, input bit v, input bit wr, input bit rd,
                         input logic [1:0] sz, input bit uns, input logic [31:0] a,
                         input logic [31:0] wd);
        int  nb;
        int  i;
        int  lo;
        bit  req;
        bit  m;
        if (r) begin
            e_addr = 0; e_aluw = 0; e_valid = 0; e_rd = 0; e_rd_known = 1; e_mis = 0;
        end else if (!st) begin
            nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            req = v && (wr || rd);
            m   = req && ((sz == 2'd3) || ((a % nb) != 0));
            i   = int'((a / 4) % 1024);
            lo  = int'(a % 4);
            e_addr = a; e_aluw = a; e_valid = v; e_mis = m;
            e_rd = 0; e_rd_known = 1;
            if (req && rd && !m) begin
                if (known[i]) e_rd = ref_load(mdl_mem[i], nb, lo, uns);
                else          e_rd_known = 0;
            end
            if (req && wr && !m) begin
                for (int k = 0; k < nb; k++)
                    mdl_mem[i][8*(lo+k) +: 8] = wd[8*k +: 8];
                if (nb == 4) known[i] = 1;
            end
        end
    endtask

    task automatic step(input string tag, input bit r, input bit st, input bit v, input bit wr,
                        input bit rd, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
        reset          = r;
        bif.stallM     = st;
        bif.validM     = v;
        bif.memWriteM  = wr;
        bif.memReadM   = rd;
        bif.sizeM      = sz;
        bif.unsignedM  = uns;
        bif.ALUOutM    = a;
        bif.writeDataM = wd;
        @(posedge clk);
        model(r, st, v, wr, rd, sz, uns, a, wd);
        #1;
        chk({tag, ".address"}, bif.address, e_addr);
        chk({tag, ".aluw"},    bif.ALUOutW, e_aluw);
        chk({tag, ".validW"},  {31'd0, bif.validW}, {31'd0, e_valid});
        chk({tag, ".mis"},     {31'd0, bif.misalignW}, {31'd0, e_mis});
        if (e_rd_known) chk({tag, ".rdata"}, bif.readDataW, e_rd);
    endtask

    task automatic sw(input string tag, input logic [31:0] a, input logic [31:0] d);
        step(tag, 0, 0, 1, 1, 0, 2'd2, 0, a, d);
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input bit uns, input logic [31:0] a);
        step(tag, 0, 0, 1, 0, 1, sz, uns, a, 32'h0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) begin
            known[i]   = 0;
            mdl_mem[i] = 0;
        end

        step("rst0", 1, 0, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
        step("rst1", 1, 1, 1, 1, 0, 2'd2, 0, 32'h40, 32'h5);
        chk("rst.zero", bif.readDataW | bif.address | bif.ALUOutW, 32'h0);
        step("idle", 0, 0, 1, 0, 0, 2'd2, 0, 32'h1234, 32'h0);
        chk("idle.validW", {31'd0, bif.validW}, 32'd1);

        for (int w = 0; w < 32; w++) sw("init", w * 4, $urandom);

        sw("sw10", 32'h10, 32'hDEADBEEF);
        ld("lb13", 2'd0, 0, 32'h13);  chk("lb13.k",  bif.readDataW, 32'hFFFFFFDE);
        ld("lbu13", 2'd0, 1, 32'h13); chk("lbu13.k", bif.readDataW, 32'h000000DE);
        ld("lh10", 2'd1, 0, 32'h10);  chk("lh10.k",  bif.readDataW, 32'hFFFFBEEF);
        ld("lw10", 2'd2, 0, 32'h10);  chk("lw10.k",  bif.readDataW, 32'hDEADBEEF);

        sw("sw12mis", 32'h12, 32'h11111111);
        chk("sw12mis.k", {31'd0, bif.misalignW}, 32'd1);
        ld("lw10b", 2'd2, 0, 32'h10); chk("lw10b.k", bif.readDataW, 32'hDEADBEEF);

        sw("sw1004", 32'h1004, 32'hA5A5A5A5);
        ld("lw004", 2'd2, 0, 32'h4);  chk("lw004.k", bif.readDataW, 32'hA5A5A5A5);

        for (int s = 0; s < 3; s++) step("stall", 0, 1, 1, 1, 0, 2'd2, 0, 32'h20, 32'h1);
        sw("sw20", 32'h20, 32'h1);
        ld("lw20", 2'd2, 0, 32'h20);  chk("lw20.k", bif.readDataW, 32'h1);

        step("rstsw", 1, 0, 1, 1, 0, 2'd2, 0, 32'h30, 32'h7);
        ld("lw30", 2'd2, 0, 32'h30);

        for (int n = 0; n < 600; n++) begin
            sz = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2)
                 | 32'($urandom_range(0, 3));
            step("rnd", $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                 sz, 1'($urandom), a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage for the 32-bit MIPS core: registers the M-stage address, performs byte/half/word stores and loads against an internal synchronous data RAM, and delivers sign/zero-extended load data to the W stage one cycle later. It generalises the plain address register with:

- configurable memory depth;
- a valid/stall handshake;
- misalignment detection.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words, power of two, at least 4.
- INDEX_W, $clog2(DEPTH_WORDS): word-index width (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- validM  in  1  M-stage slot holds a real instruction.
- stallM  in  1  hazard-unit stall; freezes this stage.
- memWriteM  in  1  store request.
- memReadM  in  1  load request.
- sizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- unsignedM  in  1  zero-extend loads (lbu/lhu) when 1.
- ALUOutM  in  32  effective byte address.
- writeDataM  in  32  store data, right-justified.
- address  out  32  registered ALUOutM.
- ALUOutW  out  32  registered ALUOutM forwarded to W.
- validW  out  1  W-stage slot valid.
- readDataW  out  32  extended load data.
- misalignW  out  1  access in W slot was misaligned or illegal.

## Operation
- Access fires when validM=1, stallM=0, reset=0 and (memReadM or memWriteM).
- Word index is ALUOutM[2 +: INDEX_W]. Upper address bits are ignored, so out-of-range addresses alias (wrap modulo DEPTH_WORDS).
- Misaligned conditions:
  - half with ALUOutM[0]=1;
  - word with ALUOutM[1:0]!=0;
  - sizeM=11 with either request asserted.
- Misaligned store: no RAM write. Misaligned load or store: misalignW=1. Misaligned load: readDataW=0.
- Store byte enables:
  - byte: lane ALUOutM[1:0], data writeDataM[7:0] replicated to all lanes;
  - half: lanes {ALUOutM[1],0} and +1, data writeDataM[15:0] replicated;
  - word: all four lanes.
- Load: the RAM word is read synchronously. ALUOutM[1:0], sizeM and unsignedM are registered alongside it. In W the selected lane is sign-extended (unsignedM=0) or zero-extended (unsignedM=1). A word load is passed through unchanged.
- memReadM and memWriteM both 1: the store is performed and readDataW returns the old word (read-first).
- Neither request asserted: readDataW=0, misalignW=0, RAM untouched. validW and ALUOutW still follow validM and ALUOutM.
- stallM=1: no RAM write or read. address, ALUOutW, validW, readDataW and misalignW hold their values.

## Timing
- Reset values: address=0, ALUOutW=0, validW=0, readDataW=0, misalignW=0. RAM contents are not reset.
- Latency: an access accepted at edge N has address, ALUOutW, validW, readDataW and misalignW valid after edge N.
- Throughput: one access per cycle; back-to-back accesses need no bubble.
- Store at edge N followed by a load of the same word at edge N+1 returns the new data.
- Reset asserted in the same cycle as a store: the store is dropped and all outputs go to reset values.
- Reset has priority over stallM.
- Reset asserted mid-stall: the stall state is discarded.

## Structure
- mem_pkg (shared package) holds:
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL;
  - function byte_en(size, addr_lo) returning 4 bits;
  - function misaligned(size, addr_lo);
  - function load_extend(word, size, addr_lo, unsigned_ld).
- Sub-module dmem_ram: single-port synchronous RAM, DEPTH_WORDS x 32, 4-bit byte write enable, read-first, enable input used to honour stall.
- Top level contains only the W-side pipeline registers and extraction.

## Test plan
- Reset then idle: all outputs 0; validM=1 with no request -> validW=1, readDataW=0 next cycle.
- Store word 0xDEADBEEF @0x10, then lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x10 -> 0xFFFFBEEF; lw @0x10 -> 0xDEADBEEF.
- Misaligned sw @0x12 of 0x11111111, then lw @0x10 -> misalignW=1 on the store cycle; the load returns 0xDEADBEEF (unchanged).
- Aliasing with DEPTH_WORDS=1024: sw 0xA5A5A5A5 @0x1004, then lw @0x0004 -> 0xA5A5A5A5.
- Stall: sw @0x20 of 1 presented with stallM=1 for 3 cycles, then released -> outputs frozen during the stall, exactly one write occurs, lw @0x20 -> 1.
- Reset in the same cycle as sw @0x30 of 7 -> outputs 0; a later lw @0x30 returns the prior RAM content (not 7).
